// File: rtl/memory_access_stage.sv
// ----------------------------------------------------------------------------
// memory_access_stage
//
// RISC-V MEM stage plus the MEM/WB pipeline register. Issues loads and stores
// on a req/ack data-memory bus (any number of wait states), formats load data
// and registers everything the write-back stage consumes. While an access is
// outstanding, stall_o freezes the upstream pipeline. The upstream pipeline
// holds the EX/MEM inputs steady for as long as stall_o is high.
//
// Optional feature (compile-time macro MISALIGN_CHECK_EN):
//   defined   - misaligned halfword/word accesses are not issued to the bus.
//               They retire in one cycle with RegWrite_WRITEBACK = 0, and the
//               extra output misaligned_o pulses for that slot.
//   undefined - no check is made and there is no misaligned_o port. Lane
//               shifts use addr[1:0] as-is, and byte enables shifted past
//               bit 3 are dropped.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   *_MEMORY            EX/MEM register contents (controls, address, data, rd)
//   dmem_req/we/addr    data-memory request, word-aligned address
//   dmem_wdata/be       lane-replicated store data and byte enables
//   dmem_rdata/ack      read word and access-complete strobe from memory
//   stall_o             freeze IF/ID/EX and hold EX/MEM
//   *_WRITEBACK         MEM/WB register contents
//   misaligned_o        (MISALIGN_CHECK_EN only) misaligned-access flag
//
// States:
//   S_IDLE | no access outstanding; memops are issued from here
//   S_WAIT | request issued, waiting for dmem_ack; bubbles go to WB
// ----------------------------------------------------------------------------
module memory_access_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              Valid_MEMORY,
    input  logic              MemRead_MEMORY,
    input  logic              MemWrite_MEMORY,
    input  logic              MemtoReg_MEMORY,
    input  logic              RegWrite_MEMORY,
    input  logic [2:0]        funct3_MEMORY,
    input  logic [XLEN-1:0]   ALUResult_MEMORY,
    input  logic [XLEN-1:0]   StoreData_MEMORY,
    input  logic [REG_AW-1:0] Rd_MEMORY,

    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_ack,

    output logic              stall_o,

    output logic              Valid_WRITEBACK,
    output logic              MemtoReg_WRITEBACK,
    output logic              RegWrite_WRITEBACK,
    output logic [XLEN-1:0]   ReadData_WRITEBACK,
    output logic [XLEN-1:0]   Address_WRITEBACK,
`ifdef MISALIGN_CHECK_EN
    output logic              misaligned_o,
`endif
    output logic [REG_AW-1:0] Rd_WRITEBACK
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t state;

    logic              memop;
    logic              isStore;
    logic              accByte;
    logic              accHalf;
    logic [1:0]        byteOff;
    logic              misalign;
    logic              busStart;
    logic [6:0]        beWide;
    logic [XLEN-1:0]   shifted;
    logic [XLEN-1:0]   loadData;
    logic [XLEN-1:0]   capReadData;
    logic              capRegWrite;

    // ------------------------------------------------------------------
    // Access decode
    // ------------------------------------------------------------------
    assign memop   = Valid_MEMORY & (MemRead_MEMORY | MemWrite_MEMORY);
    assign isStore = MemWrite_MEMORY;
    assign byteOff = ALUResult_MEMORY[1:0];

    // funct3 100/101 only mean something for loads (LBU/LHU); every other
    // unlisted encoding falls through to a word access.
    always_comb begin
        accByte = 1'b0;
        accHalf = 1'b0;
        case (funct3_MEMORY)
            3'b000:  accByte = 1'b1;
            3'b001:  accHalf = 1'b1;
            3'b100:  accByte = ~isStore;
            3'b101:  accHalf = ~isStore;
            default: ;
        endcase
    end

`ifdef MISALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        if (memop) begin
            if (accHalf)
                misalign = byteOff[0];
            else if (!accByte)
                misalign = (byteOff != 2'b00);
        end
    end
`else
    assign misalign = 1'b0;
`endif

    assign busStart = memop & ~misalign;

    // ------------------------------------------------------------------
    // Bus drive. Address/data come straight from EX/MEM, which is held
    // while stalled, so they stay stable throughout S_WAIT. Reset gates
    // the request so an abandoned access disappears immediately.
    // ------------------------------------------------------------------
    assign dmem_req  = ~rst & ((state == S_WAIT) | ((state == S_IDLE) & busStart));
    assign stall_o   = dmem_req & ~dmem_ack;
    assign dmem_we   = isStore;
    assign dmem_addr = {ALUResult_MEMORY[XLEN-1:2], 2'b00};

    // A 7-bit enable vector lets the shift overflow; the upper bits are
    // dropped when the lanes are presented on the bus.
    always_comb begin
        if (accByte)
            beWide = 7'b000_0001 << byteOff;
        else if (accHalf)
            beWide = 7'b000_0011 << byteOff;
        else
            beWide = 7'b000_1111;
    end

    assign dmem_be = isStore ? beWide[3:0] : 4'b1111;

    always_comb begin
        if (accByte)
            dmem_wdata = {4{StoreData_MEMORY[7:0]}};
        else if (accHalf)
            dmem_wdata = {2{StoreData_MEMORY[15:0]}};
        else
            dmem_wdata = StoreData_MEMORY;
    end

    // ------------------------------------------------------------------
    // Load formatting: move the addressed lane down to bit 0, then extend.
    // funct3[2] distinguishes the unsigned variants.
    // ------------------------------------------------------------------
    assign shifted = dmem_rdata >> {byteOff, 3'b000};

    always_comb begin
        if (accByte)
            loadData = funct3_MEMORY[2] ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                        : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
        else if (accHalf)
            loadData = funct3_MEMORY[2] ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                        : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        else
            loadData = dmem_rdata;
    end

    // Only a completing bus load produces read data; ALU ops, stores and
    // misaligned accesses write zero.
    assign capReadData = (busStart & ~isStore) ? loadData : '0;
    assign capRegWrite = Valid_MEMORY & RegWrite_MEMORY & ~misalign;

    // ------------------------------------------------------------------
    // FSM and MEM/WB register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= S_IDLE;
            Valid_WRITEBACK    <= 1'b0;
            MemtoReg_WRITEBACK <= 1'b0;
            RegWrite_WRITEBACK <= 1'b0;
            ReadData_WRITEBACK <= '0;
            Address_WRITEBACK  <= '0;
            Rd_WRITEBACK       <= '0;
`ifdef MISALIGN_CHECK_EN
            misaligned_o       <= 1'b0;
`endif
        end else begin
            if ((state == S_IDLE && busStart && !dmem_ack) ||
                (state == S_WAIT && !dmem_ack)) begin
                // Access still outstanding: retire a bubble.
                state              <= S_WAIT;
                Valid_WRITEBACK    <= 1'b0;
                MemtoReg_WRITEBACK <= 1'b0;
                RegWrite_WRITEBACK <= 1'b0;
                ReadData_WRITEBACK <= '0;
                Address_WRITEBACK  <= '0;
                Rd_WRITEBACK       <= '0;
`ifdef MISALIGN_CHECK_EN
                misaligned_o       <= 1'b0;
`endif
            end else begin
                // Completed access or pass-through of a non-memory slot.
                state              <= S_IDLE;
                Valid_WRITEBACK    <= Valid_MEMORY;
                MemtoReg_WRITEBACK <= MemtoReg_MEMORY;
                RegWrite_WRITEBACK <= capRegWrite;
                ReadData_WRITEBACK <= capReadData;
                Address_WRITEBACK  <= ALUResult_MEMORY;
                Rd_WRITEBACK       <= Rd_MEMORY;
`ifdef MISALIGN_CHECK_EN
                misaligned_o       <= misalign;
`endif
            end
        end
    end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- RISC-V MEM stage plus MEM/WB pipeline register.
- Takes EX/MEM controls and ALU result, runs loads and stores on the data-memory bus with a req/ack handshake (wait states supported), and formats load data.
- Registers everything the write-back stage consumes: MemtoReg_WRITEBACK, ReadData_WRITEBACK, Address_WRITEBACK, RegWrite_WRITEBACK, Rd_WRITEBACK.
- Raises stall_o to the hazard unit while an access is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- REG_AW, 5, destination register index width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- Valid_MEMORY  input  1  EX/MEM slot holds a real instruction.
- MemRead_MEMORY  input  1  load.
- MemWrite_MEMORY  input  1  store.
- MemtoReg_MEMORY  input  1  write-back select: 1 = load data.
- RegWrite_MEMORY  input  1  register write enable.
- funct3_MEMORY  input  3  000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- ALUResult_MEMORY  input  XLEN  effective address or ALU result.
- StoreData_MEMORY  input  XLEN  rs2 value.
- Rd_MEMORY  input  REG_AW  destination register.
- dmem_req  output  1  bus request.
- dmem_we  output  1  1 = write.
- dmem_addr  output  XLEN  word-aligned address (bits[1:0] = 00).
- dmem_wdata  output  XLEN  lane-replicated store data.
- dmem_be  output  4  byte enables.
- dmem_rdata  input  XLEN  read word; valid only when dmem_ack = 1.
- dmem_ack  input  1  access complete.
- stall_o  output  1  freeze IF/ID/EX and hold the EX/MEM register.
- Valid_WRITEBACK  output  1  registered valid.
- MemtoReg_WRITEBACK  output  1  registered.
- RegWrite_WRITEBACK  output  1  registered; forced to 0 for bubbles.
- ReadData_WRITEBACK  output  XLEN  formatted load data.
- Address_WRITEBACK  output  XLEN  registered ALUResult_MEMORY.
- Rd_WRITEBACK  output  REG_AW  registered.

Behaviour:
- Reset:
  - All *_WRITEBACK outputs are 0; dmem_req = 0; stall_o = 0; FSM = IDLE.
  - Asserting rst mid-access drops dmem_req immediately. The pending access is abandoned.
  - The first ack after reset release is ignored while in IDLE with no request.
- The access condition is memop = Valid_MEMORY & (MemRead_MEMORY | MemWrite_MEMORY).
- FSM IDLE:
  - If memop, drive dmem_req = 1 combinationally, along with addr, we, be and wdata.
  - If dmem_ack is also 1 in the same cycle, capture into the WB register at the edge and stay in IDLE (zero wait states, stall_o = 0).
  - If dmem_ack = 0, assert stall_o = 1, load a bubble into the WB register (Valid = 0, RegWrite = 0) and go to WAIT.
  - If there is no memop, capture pass-through at the edge (1-cycle latency). ReadData_WRITEBACK gets 0.
- FSM WAIT:
  - Hold dmem_req = 1; addr, we, be and wdata stay stable. Upstream holds its inputs because stall_o = 1.
  - Keep loading bubbles into the WB register each cycle.
  - On dmem_ack = 1: stall_o = 0 combinationally, capture the real instruction, return to IDLE.
- Stores:
  - SB: be = 0001 << addr[1:0], wdata = {4{byte}}.
  - SH: be = 0011 << addr[1:0], wdata = {2{half}}.
  - SW: be = 1111.
  - The store's RegWrite passes through unchanged (normally 0).
- Loads: select the lane using addr[1:0].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW takes the whole word.
  - Loads always drive be = 1111.
- Unsupported funct3 on a memop: treated as a word access.
- Back-to-back memops: the second is presented in the cycle after the first one's ack, with no dead cycle.

Optional Feature:
- Macro: MISALIGN_CHECK_EN.
- Defined:
  - A halfword with addr[0] = 1 or a word with addr[1:0] != 00 is misaligned.
  - A misaligned access never asserts dmem_req and never stalls.
  - It completes in 1 cycle with RegWrite_WRITEBACK = 0.
  - It adds an output port, misaligned_o, registered alongside the WB register, that pulses 1 for that slot.
- Undefined:
  - No check and no misaligned_o port.
  - Lane shift uses addr[1:0] as-is, and be bits shifted beyond bit 3 are dropped.

Test Plan:
- ALU op, Valid = 1, RegWrite = 1, ALUResult = 0x0000_1234, Rd = 5 → next cycle: Address_WRITEBACK = 0x1234, RegWrite_WRITEBACK = 1, Rd_WRITEBACK = 5, dmem_req never 1.
- LW at 0x100, ack in the same cycle, rdata = 0xDEAD_BEEF → no stall, next cycle: ReadData_WRITEBACK = 0xDEADBEEF, MemtoReg_WRITEBACK = 1.
- LB at 0x103, ack after 3 wait cycles, rdata = 0x80FF_0000 → stall_o high for 3 cycles, 3 bubbles with RegWrite_WRITEBACK = 0, then ReadData_WRITEBACK = 0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- SH at 0x202, data 0x0000_ABCD → dmem_addr = 0x200, be = 1100, wdata = 0xABCD_ABCD, we = 1.
- Assert rst during WAIT of a load → dmem_req and stall_o drop in the same cycle, all WB outputs 0, FSM back in IDLE.
- With MISALIGN_CHECK_EN: LW at 0x102 → dmem_req stays 0, misaligned_o = 1 next cycle, RegWrite_WRITEBACK = 0.
